wb_regfile: RTL

Writeback stage that sits directly downstream of the MEM/WB pipeline latch. It selects the final result (ALU result or memory load data) using the latched MemToReg select. It commits that result into an 8-entry x 8-bit register file and serves the two decode-stage read ports. It also keeps a saturating count of committed writebacks for debug and performance visibility.

---
 rtl/wb_regfile.sv | 106 ++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback stage: selects the ALU or load result, commits it into an
// NREGS x DATA_W register file (register 0 reads as zero), serves two
// combinational read ports and keeps a saturating commit counter.
// Optional macro WB_REGFILE_BYPASS_EN forwards a pending commit to any read
// port addressing the destination register in the same cycle.
module wb_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] mem_in,
    input  logic              MemToRegmux,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  wb_count
);

    // The index space is padded to a full power of two so that any index can
    // be looked up; slots that are register 0 or beyond NREGS read as zero.
    localparam int DEPTH = 1 << ADDR_W;

    logic                 in_range;
    logic                 commit;
    logic [DATA_W-1:0]    view [DEPTH];
    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     cnt_next;

    assign wb_data = MemToRegmux ? mem_in : alu_in;

    // Range check only exists when the index can name a non-existent register.
    generate
        if (NREGS < DEPTH) begin : g_range_check
            assign in_range = (int'(rd) < NREGS);
        end else begin : g_range_full
            assign in_range = 1'b1;
        end
    endgenerate

    // Gating with rst keeps the read ports at zero during reset even when a
    // forwarded commit would otherwise be visible.
    assign commit = RegWrite && (rd != '0) && in_range && !rst;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0 || gi >= NREGS) begin : g_zero
                assign view[gi] = '0;
            end else begin : g_live
                logic [DATA_W-1:0] data_reg;

                // Capture the writeback value when this register is the commit target.
                always_ff @(posedge clk1 or posedge rst) begin
                    if (rst) begin
                        data_reg <= '0;
                    end else if (commit && (rd == ADDR_W'(gi))) begin
                        data_reg <= wb_data;
                    end
                end

                assign view[gi] = data_reg;
            end
        end
    endgenerate

    // Saturating increment: all-ones holds.
    always_comb begin
        cnt_next = cnt_reg;
        if (commit && !(&cnt_reg)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Commit counter register.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign wb_count = cnt_reg;

    // Read ports: stored contents, optionally overridden by a pending commit.
    always_comb begin
        rd1 = view[rs1];
        rd2 = view[rs2];
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (rs1 == rd)) begin
            rd1 = wb_data;
        end
        if (commit && (rs2 == rd)) begin
            rd2 = wb_data;
        end
`endif
    end

endmodule
